alarm_controller: RTL
=====================

ALARM_CONTROLLER -- requirements
Module: alarm_controller

Interface
REQ-001 Parameter RING_SEC, default 60, meaning number of TICK strobes RING stays asserted before auto-off.
REQ-002 Parameter SNOOZE_SEC, default 300, meaning number of TICK strobes spent in SNOOZED before re-ringing.
REQ-003 CLK  input  1  single system clock; all state changes on rising edge.
REQ-004 CLR_N  input  1  reset, asynchronous, active-low.
REQ-005 TICK  input  1  one-CLK-cycle 1 Hz strobe, coincident with the time counter's seconds advance.
REQ-006 SECONDS / MINUTES / HOURS  input  6/6/5  current time from the time-of-day counter.
REQ-007 MODE, MIN_ADV, HR_ADV, SNOOZE, STOP  input  1 each  debounced single-cycle button pulses, synchronous to CLK.
REQ-008 ALARM_EN  input  1  level; alarm armed when 1.
REQ-009 SETUP  output  1  registered; drives the time counter's setup input.
REQ-010 CLK_MIN_ADV, CLK_HR_ADV  output  1 each  registered one-cycle advance pulses to the time counter.
REQ-011 ALARM_MIN, ALARM_HR  output  6/5  registered stored alarm time.
REQ-012 RING  output  1  registered alarm sounder enable.
REQ-013 STATE  output  3  registered current state encoding.

Function
REQ-014 States and encoding: RUN=0, SET_TIME=1, SET_ALARM=2, RINGING=3, SNOOZED=4; codes 5-7 shall go to RUN next cycle.
REQ-015 MODE cycles RUN -> SET_TIME -> SET_ALARM -> RUN; MODE ignored in RINGING and SNOOZED.
REQ-016 SETUP = 1 exactly while STATE = SET_TIME; asserted the cycle after entry.
REQ-017 In SET_TIME, MIN_ADV / HR_ADV produce CLK_MIN_ADV / CLK_HR_ADV high for exactly the following cycle; both pulses are 0 in every other state.
REQ-018 In SET_ALARM, MIN_ADV increments ALARM_MIN 0..59 with wrap 59 -> 0, no carry into hour; HR_ADV increments ALARM_HR 0..23 with wrap 23 -> 0; update visible next cycle.
REQ-019 MIN_ADV and HR_ADV in the same cycle both take effect.
REQ-020 Trigger: in RUN with ALARM_EN = 1, TICK = 1, SECONDS = 0, MINUTES = ALARM_MIN, HOURS = ALARM_HR -> RINGING next cycle, RING = 1, ring counter cleared.
REQ-021 No trigger from SET_TIME or SET_ALARM; a match passed while in setup is lost.
REQ-022 In RINGING, ring counter increments per TICK; on the TICK that makes it reach RING_SEC -> RUN, RING = 0.
REQ-023 In RINGING, SNOOZE -> SNOOZED, RING = 0, snooze counter cleared.
REQ-024 In SNOOZED, snooze counter increments per TICK; on reaching SNOOZE_SEC -> RINGING, RING = 1, ring counter cleared; snooze repeatable without limit.
REQ-025 STOP in RINGING or SNOOZED -> RUN, RING = 0.
REQ-026 ALARM_EN = 0 while in RINGING or SNOOZED -> RUN next cycle, RING = 0.
REQ-027 Simultaneous-event priority: ALARM_EN low > STOP > SNOOZE > counter expiry > MODE > advance buttons.
REQ-028 Counter widths sized by clog2 of parameter +1; counters never wrap before reaching their limit.
REQ-029 RING = 1 exactly while STATE = RINGING.

Reset
REQ-030 CLR_N = 0 immediately forces STATE = RUN, SETUP = 0, RING = 0, CLK_MIN_ADV = CLK_HR_ADV = 0, ALARM_MIN = 0, ALARM_HR = 0, both counters 0, regardless of CLK.
REQ-031 Reset asserted mid-ring or mid-setup shall abort with no residual pulse; first state change allowed on the first CLK edge after CLR_N rises.

Verification
REQ-032 Reset, MODE x2, HR_ADV x7, MIN_ADV x30, MODE, ALARM_EN=1, time 07:29:59 then TICK to 07:30:00 -> STATE=3, RING=1 next cycle.
REQ-033 In SET_ALARM with ALARM_MIN=59, ALARM_HR=23, MIN_ADV+HR_ADV same cycle -> ALARM_MIN=0, ALARM_HR=0.
REQ-034 RINGING, 60 TICKs with no buttons -> RING falls on cycle after 60th TICK, STATE=0.
REQ-035 RINGING, SNOOZE, 300 TICKs -> STATE=3, RING=1; then STOP and SNOOZE same cycle -> STATE=0.
REQ-036 MODE once, MIN_ADV pulse -> SETUP=1, CLK_MIN_ADV high exactly one cycle; MODE in RINGING -> no state change.
REQ-037 CLR_N low between clock edges while RINGING -> RING=0 and STATE=0 before the next edge.

Source files
------------

// File: rtl/alarm_controller_if.sv
// Button, time-of-day and alarm status signals between the alarm controller and its surroundings.
// The slave modport is the controller side; the master modport is the driver/observer side.
interface alarm_controller_if;
  logic       tick;
  logic [5:0] seconds;
  logic [5:0] minutes;
  logic [4:0] hours;
  logic       mode;
  logic       min_adv;
  logic       hr_adv;
  logic       snooze;
  logic       stop;
  logic       alarm_en;

  logic       setup;
  logic       clk_min_adv;
  logic       clk_hr_adv;
  logic [5:0] alarm_min;
  logic [4:0] alarm_hr;
  logic       ring;
  logic [2:0] state;

  modport slave (
    input  tick, seconds, minutes, hours, mode, min_adv, hr_adv, snooze, stop, alarm_en,
    output setup, clk_min_adv, clk_hr_adv, alarm_min, alarm_hr, ring, state
  );

  modport master (
    output tick, seconds, minutes, hours, mode, min_adv, hr_adv, snooze, stop, alarm_en,
    input  setup, clk_min_adv, clk_hr_adv, alarm_min, alarm_hr, ring, state
  );
endinterface

// File: rtl/alarm_controller.sv
// Alarm clock mode FSM: time/alarm setup, alarm trigger, ring timeout and snooze; all outputs registered, 1-cycle latency.
// No backpressure: every button pulse and TICK is consumed in the cycle it arrives.
module alarm_controller #(
  parameter int RING_SEC   = 60,
  parameter int SNOOZE_SEC = 300
) (
  input  logic               clk_i,
  input  logic               clr_n_i,
  alarm_controller_if.slave  ctl
);

  localparam int RW = $clog2(RING_SEC) + 1;
  localparam int SW = $clog2(SNOOZE_SEC) + 1;
  localparam logic [RW-1:0] RING_LAST = RW'(RING_SEC - 1);
  localparam logic [SW-1:0] SNZ_LAST  = SW'(SNOOZE_SEC - 1);

  typedef enum logic [2:0] {
    RUN       = 3'd0,
    SET_TIME  = 3'd1,
    SET_ALARM = 3'd2,
    RINGING   = 3'd3,
    SNOOZED   = 3'd4
  } state_e;

  state_e        state_q, state_d;
  logic [RW-1:0] ring_cnt_q, ring_cnt_d;
  logic [SW-1:0] snz_cnt_q, snz_cnt_d;
  logic [5:0]    alarm_min_q, alarm_min_d;
  logic [4:0]    alarm_hr_q, alarm_hr_d;
  logic          min_adv_q, min_adv_d;
  logic          hr_adv_q, hr_adv_d;
  logic          setup_q, ring_q;
  logic          match;

  // The alarm fires only on the TICK that lands exactly on hh:mm:00.
  assign match = ctl.alarm_en && ctl.tick && (ctl.seconds == 6'd0) &&
                 (ctl.minutes == alarm_min_q) && (ctl.hours == alarm_hr_q);

  always_comb begin
    state_d     = state_q;
    ring_cnt_d  = ring_cnt_q;
    snz_cnt_d   = snz_cnt_q;
    alarm_min_d = alarm_min_q;
    alarm_hr_d  = alarm_hr_q;
    min_adv_d   = 1'b0;
    hr_adv_d    = 1'b0;

    case (state_q)
      RUN: begin
        if (match) begin
          state_d    = RINGING;
          ring_cnt_d = '0;
        end else if (ctl.mode) begin
          state_d = SET_TIME;
        end
      end

      SET_TIME: begin
        if (ctl.mode) begin
          state_d = SET_ALARM;
        end else begin
          min_adv_d = ctl.min_adv;
          hr_adv_d  = ctl.hr_adv;
        end
      end

      SET_ALARM: begin
        if (ctl.mode) begin
          state_d = RUN;
        end else begin
          if (ctl.min_adv) begin
            alarm_min_d = (alarm_min_q == 6'd59) ? 6'd0 : alarm_min_q + 6'd1;
          end
          if (ctl.hr_adv) begin
            alarm_hr_d = (alarm_hr_q == 5'd23) ? 5'd0 : alarm_hr_q + 5'd1;
          end
        end
      end

      RINGING: begin
        if (!ctl.alarm_en || ctl.stop) begin
          state_d = RUN;
        end else if (ctl.snooze) begin
          state_d   = SNOOZED;
          snz_cnt_d = '0;
        end else if (ctl.tick) begin
          if (ring_cnt_q == RING_LAST) begin
            state_d = RUN;
          end else begin
            ring_cnt_d = ring_cnt_q + 1'b1;
          end
        end
      end

      SNOOZED: begin
        if (!ctl.alarm_en || ctl.stop) begin
          state_d = RUN;
        end else if (ctl.tick) begin
          if (snz_cnt_q == SNZ_LAST) begin
            state_d    = RINGING;
            ring_cnt_d = '0;
          end else begin
            snz_cnt_d = snz_cnt_q + 1'b1;
          end
        end
      end

      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk_i or negedge clr_n_i) begin
    if (!clr_n_i) begin
      state_q     <= RUN;
      ring_cnt_q  <= '0;
      snz_cnt_q   <= '0;
      alarm_min_q <= '0;
      alarm_hr_q  <= '0;
      min_adv_q   <= 1'b0;
      hr_adv_q    <= 1'b0;
      setup_q     <= 1'b0;
      ring_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      ring_cnt_q  <= ring_cnt_d;
      snz_cnt_q   <= snz_cnt_d;
      alarm_min_q <= alarm_min_d;
      alarm_hr_q  <= alarm_hr_d;
      min_adv_q   <= min_adv_d;
      hr_adv_q    <= hr_adv_d;
      // Decoded from next state so these flags track STATE with no extra lag.
      setup_q     <= (state_d == SET_TIME);
      ring_q      <= (state_d == RINGING);
    end
  end

  assign ctl.state       = state_q;
  assign ctl.setup       = setup_q;
  assign ctl.ring        = ring_q;
  assign ctl.clk_min_adv = min_adv_q;
  assign ctl.clk_hr_adv  = hr_adv_q;
  assign ctl.alarm_min   = alarm_min_q;
  assign ctl.alarm_hr    = alarm_hr_q;

endmodule
